// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core tile sequencer: state encoding,
// inst bit positions, idle word and the psum request bundle.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_FETCH,
    S_W_LOAD,
    S_A_FETCH,
    S_A_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic {
    PH_RD,
    PH_WR
  } acc_ph_t;

  localparam int INST_W  = 39;
  localparam int XA_W    = 11;
  localparam int PA_W    = 14;
  localparam int MAX_LEN = 64;
  // xmem read latency; l0_wr trails each fetch address by this many cycles
  localparam int XRD_LAT = 1;

  localparam int B_ACC      = 36;
  localparam int B_CEN_P    = 35;
  localparam int B_WEN_P    = 34;
  localparam int B_AP_HI    = 33;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_HI    = 17;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [INST_W-1:0] IDLE_INST = 39'h0C000C0000;

  typedef struct packed {
    logic            acc;
    logic            cen;
    logic            wen;
    logic [PA_W-1:0] addr;
    logic            ofifo_rd;
  } pmem_req_t;

  localparam pmem_req_t PMEM_IDLE = '{acc: 1'b0, cen: 1'b1, wen: 1'b1,
                                      addr: '0, ofifo_rd: 1'b0};

endpackage

// File: rtl/core_seq_drain.sv
// OFIFO drain engine: counts drained words and builds the ofifo_rd / pmem fields.
// CORE_SEQ_ACC_EN selects a two-cycle read-then-accumulate-write per word.
module core_seq_drain
  import core_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  input  logic [CNT_W-1:0] len,
  input  logic [PA_W-1:0]  p_base,
  input  logic             ofifo_valid,
  output pmem_req_t        req,
  output logic             drained
);

  logic [CNT_W-1:0] j;
  logic [PA_W-1:0]  wr_addr;
  logic             take;
  logic             j_inc;
  pmem_req_t        req_d;

  assign wr_addr = p_base + PA_W'(j);
  assign drained = (j == len);
  assign take    = active && !drained && ofifo_valid;

`ifdef CORE_SEQ_ACC_EN
  acc_ph_t ph, ph_n;

  always_ff @(posedge clk) begin
    if (reset || clear) ph <= PH_RD;
    else                ph <= ph_n;
  end

  // a word in flight always finishes its write phase; ofifo_valid is not looked at then
  always_comb begin
    ph_n = ph;
    case (ph)
      PH_RD:   if (take) ph_n = PH_WR;
      PH_WR:   ph_n = PH_RD;
      default: ph_n = PH_RD;
    endcase
  end

  always_comb begin
    req_d = PMEM_IDLE;
    j_inc = 1'b0;
    if (ph == PH_WR) begin
      req_d.acc  = 1'b1;
      req_d.cen  = 1'b0;
      req_d.wen  = 1'b0;
      req_d.addr = wr_addr;
      j_inc      = 1'b1;
    end else if (take) begin
      req_d.ofifo_rd = 1'b1;
      req_d.cen      = 1'b0;
      req_d.addr     = wr_addr;
    end
  end
`else
  always_comb begin
    req_d = PMEM_IDLE;
    j_inc = 1'b0;
    if (take) begin
      req_d.ofifo_rd = 1'b1;
      req_d.cen      = 1'b0;
      req_d.wen      = 1'b0;
      req_d.addr     = wr_addr;
      j_inc          = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      j   <= '0;
      req <= PMEM_IDLE;
    end else begin
      req <= req_d;
      if (j_inc) j <= j + CNT_W'(1);
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Tile sequencer for core: weight fetch/load, activation fetch/execute and psum drain.
// Define CORE_SEQ_ACC_EN to accumulate into psum instead of overwriting.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int row   = 8,
  parameter int col   = 8,
  parameter int LEN_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [XA_W-1:0]   w_base,
  input  logic [XA_W-1:0]   a_base,
  input  logic [PA_W-1:0]   p_base,
  input  logic [LEN_W-1:0]  a_len,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] ROW_C = CNT_W'(row);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);

  if (row < 1 || col < 1) begin : g_bad_geom
    $error("core_seq_ctrl: row and col must be positive");
  end

  typedef struct packed {
    logic [XA_W-1:0]  w_base;
    logic [XA_W-1:0]  a_base;
    logic [PA_W-1:0]  p_base;
    logic [CNT_W-1:0] len;
  } cfg_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  cfg_t             cfg, cfg_n, cfg_in;

  logic             fetch_d, l0_rd_d, load_d, exec_d, busy_d, done_d;
  logic [XA_W-1:0]  xbase, xaddr_d, xaddr;
  logic [XRD_LAT:0] vld_pipe;
  logic             l0_rd_q, load_q, exec_q;

  pmem_req_t        preq;
  logic             drained;
  logic             drain_clr, drain_act;

  always_comb begin
    cfg_in.w_base = w_base;
    cfg_in.a_base = a_base;
    cfg_in.p_base = p_base;
    cfg_in.len    = (CNT_W'(a_len) > MAX_C) ? MAX_C : CNT_W'(a_len);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      cfg   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cfg   <= cfg_n;
    end
  end

  // fetch states run one extra cycle so the last read lands in L0
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cfg_n   = cfg;
    case (state)
      S_IDLE: if (start) begin
        cfg_n   = cfg_in;
        cnt_n   = '0;
        state_n = (cfg_in.len == '0) ? S_DONE : S_W_FETCH;
      end
      S_W_FETCH: if (cnt == ROW_C) begin
        state_n = S_W_LOAD;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      S_W_LOAD: if (cnt == ROW_C - CNT_W'(1)) begin
        state_n = S_A_FETCH;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      S_A_FETCH: if (cnt == cfg.len) begin
        state_n = S_A_EXEC;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      S_A_EXEC: if (cnt == cfg.len - CNT_W'(1)) begin
        state_n = S_DRAIN;
        cnt_n   = '0;
      end else cnt_n = cnt + CNT_W'(1);
      S_DRAIN: if (drained) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state and registered on the same edge
  always_comb begin
    fetch_d = (state_n == S_W_FETCH && cnt_n < ROW_C) ||
              (state_n == S_A_FETCH && cnt_n < cfg_n.len);
    xbase   = (state_n == S_A_FETCH) ? cfg_n.a_base : cfg_n.w_base;
    xaddr_d = fetch_d ? xbase + XA_W'(cnt_n) : '0;
    l0_rd_d = (state_n == S_W_LOAD) || (state_n == S_A_EXEC);
    load_d  = (state_n == S_W_LOAD);
    exec_d  = (state_n == S_A_EXEC);
    busy_d  = (state_n != S_IDLE);
    done_d  = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      xaddr    <= '0;
      l0_rd_q  <= 1'b0;
      load_q   <= 1'b0;
      exec_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[XRD_LAT-1:0], fetch_d};
      xaddr    <= xaddr_d;
      l0_rd_q  <= l0_rd_d;
      load_q   <= load_d;
      exec_q   <= exec_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign drain_clr = (state == S_IDLE);
  assign drain_act = (state == S_A_EXEC) || (state == S_DRAIN);

  core_seq_drain #(.CNT_W(CNT_W)) u_drain (
    .clk        (clk),
    .reset      (reset),
    .clear      (drain_clr),
    .active     (drain_act),
    .len        (cfg.len),
    .p_base     (cfg.p_base),
    .ofifo_valid(ofifo_valid),
    .req        (preq),
    .drained    (drained)
  );

  always_comb begin
    inst                   = '0;
    inst[B_ACC]            = preq.acc;
    inst[B_CEN_P]          = preq.cen;
    inst[B_WEN_P]          = preq.wen;
    inst[B_AP_HI:B_AP_LO]  = preq.addr;
    inst[B_CEN_X]          = ~vld_pipe[0];
    inst[B_WEN_X]          = 1'b1;
    inst[B_AX_HI:B_AX_LO]  = xaddr;
    inst[B_OFIFO_RD]       = preq.ofifo_rd;
    inst[B_IFIFO_WR]       = 1'b0;
    inst[B_IFIFO_RD]       = 1'b0;
    inst[B_L0_RD]          = l0_rd_q;
    inst[B_L0_WR]          = vld_pipe[XRD_LAT];
    inst[B_EXEC]           = exec_q;
    inst[B_LOAD]           = load_q;
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: a tile-timeline model predicts inst/busy/done every cycle.
module tb_core_seq_ctrl;

  localparam int ROW = 8;
  localparam logic [38:0] IDLE_W = 39'h0C000C0000;
`ifdef CORE_SEQ_ACC_EN
  localparam bit ACC = 1'b1;
  localparam int NOM_HI = 50;
`else
  localparam bit ACC = 1'b0;
  localparam int NOM_HI = 42;
`endif

  logic        clk, reset, start, ofifo_valid;
  logic [10:0] w_base, a_base;
  logic [13:0] p_base;
  logic [6:0]  a_len;
  logic [38:0] inst;
  logic        busy, done;

  core_seq_ctrl #(.row(ROW), .col(8), .LEN_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .a_base(a_base),
    .p_base(p_base), .a_len(a_len), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [38:0] mk_inst(bit cenx, logic [10:0] ax, bit l0wr, bit l0rd,
      bit ld, bit ex, bit acc, bit cenp, bit wenp, logic [13:0] ap, bit ofrd);
    return {2'b00, acc, cenp, wenp, ap, cenx, 1'b1, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, ex, ld};
  endfunction

  // model: tile time tau counts cycles since start was accepted
  bit          m_act = 0, m_done = 0, m_ph = 0;
  int          m_tau = 0, m_n = 0, m_j = 0;
  logic [10:0] m_w, m_a;
  logic [13:0] m_p;
  bit          d_rd, d_cen, d_wen, d_acc;
  logic [13:0] d_ap;
  logic [38:0] e_inst = IDLE_W;
  bit          e_busy = 0, e_done = 0;

  always @(posedge clk) begin
    int ex0, ex_end;
    bit cenx, l0wr, l0rd, ld, ex;
    logic [10:0] ax;
    d_rd = 0; d_cen = 1; d_wen = 1; d_acc = 0; d_ap = '0;
    ex0 = 2*ROW + m_n + 3;
    ex_end = 2*ROW + 2*m_n + 2;
    if (reset) begin
      m_act = 0; m_done = 0; m_ph = 0; m_j = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_act) begin
      if (start) begin
        m_w = w_base; m_a = a_base; m_p = p_base;
        m_n = (a_len > 64) ? 64 : int'(a_len);
        m_j = 0; m_ph = 0; m_tau = 1;
        if (m_n == 0) m_done = 1; else m_act = 1;
      end
    end else if (m_tau > ex_end && m_j == m_n) begin
      m_act = 0; m_done = 1;
    end else begin
      if (m_ph) begin
        d_cen = 0; d_wen = 0; d_acc = 1; d_ap = 14'(m_p + m_j); m_j++; m_ph = 0;
      end else if (m_tau >= ex0 && m_j < m_n && ofifo_valid) begin
        d_rd = 1; d_cen = 0; d_ap = 14'(m_p + m_j);
        if (ACC) m_ph = 1;
        else begin d_wen = 0; m_j++; end
      end
      m_tau++;
    end
    cenx = 1; ax = '0; l0wr = 0; l0rd = 0; ld = 0; ex = 0;
    if (m_act) begin
      if (m_tau >= 1 && m_tau <= ROW) begin cenx = 0; ax = 11'(m_w + m_tau - 1); end
      if (m_tau >= 2 && m_tau <= ROW + 1) l0wr = 1;
      if (m_tau >= ROW + 2 && m_tau <= 2*ROW + 1) begin l0rd = 1; ld = 1; end
      if (m_tau >= 2*ROW + 2 && m_tau <= 2*ROW + 1 + m_n) begin
        cenx = 0; ax = 11'(m_a + m_tau - 2*ROW - 2);
      end
      if (m_tau >= 2*ROW + 3 && m_tau <= 2*ROW + 2 + m_n) l0wr = 1;
      if (m_tau >= 2*ROW + m_n + 3 && m_tau <= 2*ROW + 2*m_n + 2) begin l0rd = 1; ex = 1; end
    end
    e_inst = mk_inst(cenx, ax, l0wr, l0rd, ld, ex, d_acc, d_cen, d_wen, d_ap, d_rd);
    e_busy = m_act || m_done;
    e_done = m_done;
  end

  // per-cycle compare plus observation queues for the literal checks
  int cyc = 0, n_load = 0, n_exec = 0, n_done = 0, n_acc = 0, n_nonidle = 0;
  logic [10:0] xq[$];
  logic [13:0] pq[$], rq[$];
  int rdq[$];

  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      chk("inst", {25'b0, inst}, {25'b0, e_inst});
      chk("busy", {63'b0, busy}, {63'b0, e_busy});
      chk("done", {63'b0, done}, {63'b0, e_done});
      if (!inst[19]) xq.push_back(inst[17:7]);
      if (!inst[35] && !inst[34]) pq.push_back(inst[33:20]);
      if (!inst[35] && inst[34]) rq.push_back(inst[33:20]);
      if (inst[6]) rdq.push_back(cyc);
      n_load += int'(inst[0]);
      n_exec += int'(inst[1]);
      n_done += int'(done);
      n_acc  += int'(inst[36]);
      if (inst !== IDLE_W) n_nonidle++;
    end
  end

  task automatic clear_obs();
    xq.delete(); pq.delete(); rq.delete(); rdq.delete();
    n_load = 0; n_exec = 0; n_done = 0; n_acc = 0; n_nonidle = 0;
  endtask

  // vmode 0: random ofifo_valid and input noise; 1: valid only for tau in [vlo,vhi]
  task automatic run_tile(input logic [10:0] wb, input logic [10:0] ab, input logic [13:0] pb,
      input logic [6:0] len, input int vmode, input int vlo, input int vhi,
      input int abort_at, output int tdone);
    int t;
    clear_obs();
    w_base = wb; a_base = ab; p_base = pb; a_len = len; start = 1;
    @(posedge clk); #1;
    start = 0;
    t = 1;
    while (!done && t < 600) begin
      if (t == abort_at) begin
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("abort_inst", {25'b0, inst}, {25'b0, IDLE_W});
        chk("abort_busy", {63'b0, busy}, 64'd0);
        tdone = -1;
        ofifo_valid = 0;
        return;
      end
      if (vmode == 1) ofifo_valid = (t >= vlo && t <= vhi);
      else begin
        ofifo_valid = ($urandom_range(0, 3) != 0);
        start  = ($urandom_range(0, 7) == 0);
        w_base = 11'($urandom); a_base = 11'($urandom);
        p_base = 14'($urandom); a_len = 7'($urandom);
      end
      @(posedge clk); #1;
      t++;
    end
    start = 0; ofifo_valid = 0;
    chk("tile_timeout", {63'b0, (t < 600)}, 64'd1);
    tdone = t;
    @(posedge clk); #1;
  endtask

  task automatic nominal_checks(input int td);
    chk("nom_xq_size", xq.size(), 16);
    for (int i = 0; i < 8; i++) begin
      chk("nom_w_addr", {53'b0, xq[i]}, i);
      chk("nom_a_addr", {53'b0, xq[8+i]}, 16 + i);
      chk("nom_p_addr", {50'b0, pq[i]}, i);
    end
    chk("nom_pq_size", pq.size(), 8);
    chk("nom_loads", n_load, 8);
    chk("nom_execs", n_exec, 8);
    chk("nom_done_pulses", n_done, 1);
    if (!ACC) chk("nom_done_cycle", td, 44);
  endtask

  initial begin
    int td;
    int wexp[4] = '{2046, 2047, 0, 1};
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int td, len, ab_i;
    int wexp[4];
    wexp = '{2046, 2047, 0, 1};
    reset = 1; start = 0; ofifo_valid = 0;
    w_base = 0; a_base = 0; p_base = 0; a_len = 0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    chk("reset_inst", {25'b0, inst}, 64'h0C000C0000);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    reset = 0;
    @(posedge clk); #1;

    run_tile(11'd0, 11'd16, 14'd0, 7'd8, 1, 35, NOM_HI, 0, td);
    nominal_checks(td);

    run_tile(11'd300, 11'd2046, 14'd16380, 7'd4, 0, 0, 0, 0, td);
    chk("wrap_xq_size", xq.size(), ROW + 4);
    for (int i = 0; i < 4; i++) chk("wrap_a_addr", {53'b0, xq[ROW+i]}, wexp[i]);

    run_tile(11'd5, 11'd5, 14'd5, 7'd0, 0, 0, 0, 0, td);
    chk("zero_done_cycle", td, 1);
    chk("zero_nonidle", n_nonidle, 0);
    chk("zero_done_pulses", n_done, 1);

    run_tile(11'd7, 11'd100, 14'd9, 7'd100, 0, 0, 0, 0, td);
    chk("clamp_execs", n_exec, 64);
    chk("clamp_writes", ACC ? rq.size() : pq.size(), 64);

    run_tile(11'd0, 11'd16, 14'd0, 7'd8, 1, 35, NOM_HI, 2*ROW + 8 + 5, td);
    @(posedge clk); #1;
    run_tile(11'd0, 11'd16, 14'd0, 7'd8, 1, 35, NOM_HI, 0, td);
    nominal_checks(td);

    if (ACC) begin
      run_tile(11'd0, 11'd4, 14'd100, 7'd2, 1, 2*ROW + 5, 2*ROW + 25, 0, td);
      chk("acc_rd_pulses", rdq.size(), 2);
      chk("acc_rd_spacing", rdq[1] - rdq[0], 2);
      chk("acc_reads_0", {50'b0, rq[0]}, 100);
      chk("acc_reads_1", {50'b0, rq[1]}, 101);
      chk("acc_writes_0", {50'b0, pq[0]}, 100);
      chk("acc_writes_1", {50'b0, pq[1]}, 101);
      chk("acc_pulses", n_acc, 2);
    end

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = $urandom_range(65, 127);
        default: len = $urandom_range(1, 20);
      endcase
      ab_i = $urandom_range(0, 2047);
      run_tile(11'($urandom), 11'(ab_i), 14'($urandom), 7'(len), 0, 0, 0,
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, 40) : 0, td);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
